// File: rtl/vball_pkg.sv
// vball_pkg: constants and types shared by the sprite-RAM buffer and the sprite engine
package vball_pkg;
  localparam int OBJ_BYTES = 256;
  localparam int AW = 8;
  localparam logic [8:0] VBL_LINE_DEF = 9'd240;
  localparam logic [1:0] OFS_Y = 2'd0;
  localparam logic [1:0] OFS_ATTR = 2'd1;
  localparam logic [1:0] OFS_ID = 2'd2;
  localparam logic [1:0] OFS_X = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_COPY, S_DRAIN} state_t;
endpackage

// File: rtl/vball_spram_buf_if.sv
// vball_spram_buf_if: CPU live-list port and sprite-engine display read port
interface vball_spram_buf_if;
  import vball_pkg::*;
  logic [AW-1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic cpu_we;
  logic [7:0] cpu_dout;
  logic [AW-1:0] sma;
  logic [7:0] smd;
  modport master(output cpu_addr, cpu_din, cpu_we, sma, input cpu_dout, smd);
  modport slave(input cpu_addr, cpu_din, cpu_we, sma, output cpu_dout, smd);
endinterface

// File: rtl/vball_dpram.sv
// vball_dpram: dual-port sync RAM, port A read/write, port B read, registered read-before-write outputs
module vball_dpram
  import vball_pkg::*;
#(
  parameter int DEPTH = OBJ_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_a_addr,
  input  logic [7:0]    i_a_din,
  input  logic          i_a_we,
  output logic [7:0]    o_a_dout,
  input  logic [AW-1:0] i_b_addr,
  output logic [7:0]    o_b_dout
);
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_a_dout, r_b_dout;
  always_ff @(posedge clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_dout <= '0;
      r_b_dout <= '0;
    end else begin
      r_a_dout <= r_mem[i_a_addr];
      r_b_dout <= r_mem[i_b_addr];
    end
  end
  assign o_a_dout = r_a_dout;
  assign o_b_dout = r_b_dout;
endmodule

// File: rtl/vball_spram_buf.sv
// vball_spram_buf: copies the CPU live sprite list into the display buffer once per frame at VBL_LINE
module vball_spram_buf
  import vball_pkg::*;
#(
  parameter logic [8:0] VBL_LINE = VBL_LINE_DEF,
  parameter int OBJ_BYTES = vball_pkg::OBJ_BYTES
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [8:0]          vcount,
  input  logic                copy_en,
  vball_spram_buf_if.slave    bus,
  output logic                busy,
  output logic                done
);
  state_t r_state, w_next;
  logic [8:0] r_vcount;
  logic [AW-1:0] r_rd_ptr, r_wr_ptr, w_rd_inc;
  logic r_wr_en, w_trig, w_carry;
  logic [7:0] w_live_q, w_disp_a_q;
  assign {w_carry, w_rd_inc} = {1'b0, r_rd_ptr} + 9'd1;
  assign w_trig = vcount == VBL_LINE && r_vcount != vcount && copy_en;
  always_comb begin
    w_next = r_state == S_IDLE ? (w_trig ? S_COPY : S_IDLE) :
             r_state == S_COPY ? (w_carry ? S_DRAIN : S_COPY) : S_IDLE;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_vcount <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_wr_en  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_vcount <= vcount;
      r_rd_ptr <= r_state == S_COPY ? w_rd_inc : '0;
      r_wr_ptr <= r_rd_ptr;
      r_wr_en  <= r_state == S_COPY;
    end
  end
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DRAIN;
  vball_dpram #(.DEPTH(OBJ_BYTES)) u_live (
    .clk      (clk_sys),
    .rst      (reset),
    .i_a_addr (bus.cpu_addr),
    .i_a_din  (bus.cpu_din),
    .i_a_we   (bus.cpu_we),
    .o_a_dout (bus.cpu_dout),
    .i_b_addr (r_rd_ptr),
    .o_b_dout (w_live_q)
  );
  // a write already in flight when reset arrives is dropped so the abort is clean
  vball_dpram #(.DEPTH(OBJ_BYTES)) u_disp (
    .clk      (clk_sys),
    .rst      (reset),
    .i_a_addr (r_wr_ptr),
    .i_a_din  (w_live_q),
    .i_a_we   (r_wr_en & ~reset),
    .o_a_dout (w_disp_a_q),
    .i_b_addr (bus.sma),
    .o_b_dout (bus.smd)
  );
endmodule

// File: tb/tb_vball_spram_buf.sv
// tb_vball_spram_buf: directed scoreboard bench for the sprite-RAM double buffer
module tb_vball_spram_buf;
  logic clk_sys = 0;
  logic reset = 1;
  logic [8:0] vcount = 0;
  logic copy_en = 1;
  logic busy, done;
  vball_spram_buf_if bus();
  vball_spram_buf dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .vcount  (vcount),
    .copy_en (copy_en),
    .bus     (bus.slave),
    .busy    (busy),
    .done    (done)
  );
  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;
  logic eng_req = 0, cpu_req = 0, p_eng = 0, p_cpu = 0;
  logic [15:0] q_eng[$];
  logic [15:0] q_cpu[$];
  logic [7:0] live_m[256];
  logic [7:0] disp_m[256];
  logic [7:0] pre_m[256];
  int nb, nd, dpos, endc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk_sys) begin
    p_eng <= eng_req;
    p_cpu <= cpu_req;
  end

  always @(negedge clk_sys) begin
    logic [15:0] e;
    if (p_eng) begin
      if (q_eng.size() == 0) check("smd_underflow", 1, 0);
      else begin
        e = q_eng.pop_front();
        check($sformatf("smd@%02h", e[15:8]), {24'd0, bus.smd}, {24'd0, e[7:0]});
      end
    end
    if (p_cpu) begin
      if (q_cpu.size() == 0) check("cpu_underflow", 1, 0);
      else begin
        e = q_cpu.pop_front();
        check($sformatf("cpu_dout@%02h", e[15:8]), {24'd0, bus.cpu_dout}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    bus.cpu_addr = a; bus.cpu_din = d; bus.cpu_we = 1;
    live_m[a] = d;
    tick();
    bus.cpu_we = 0;
  endtask

  task automatic eng_issue(input logic [7:0] a, input logic [7:0] e);
    bus.sma = a; eng_req = 1;
    q_eng.push_back({a, e});
  endtask

  task automatic eng_rd(input logic [7:0] a);
    eng_issue(a, disp_m[a]);
    tick();
    eng_req = 0;
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    bus.cpu_addr = a; cpu_req = 1;
    q_cpu.push_back({a, live_m[a]});
    tick();
    cpu_req = 0;
  endtask

  // mode 0 plain, 1 mid-copy CPU writes, 2 engine polls 0x80 and copy_en drops, 3 reset at T+100
  task automatic run_copy(input int mode);
    logic [7:0] old80;
    old80 = disp_m[8'h80];
    vcount = 239; tick();
    vcount = 240; tick();
    nb = 0; nd = 0; dpos = 0; endc = 0;
    for (int c = 1; c < 400; c++) begin
      endc = c;
      if (busy) nb++;
      if (done) begin nd++; dpos = c; end
      if (!busy) break;
      bus.cpu_we = mode == 1 && (c == 30 || c == 31);
      bus.cpu_addr = c == 30 ? 8'h10 : 8'hF0;
      bus.cpu_din = c == 30 ? 8'hC3 : 8'h3C;
      reset = mode == 3 && c == 100;
      if (mode == 2) begin
        copy_en = c < 50;
        eng_issue(8'h80, c <= 130 ? old80 : live_m[8'h80]);
      end
      tick();
    end
    bus.cpu_we = 0; reset = 0; eng_req = 0; copy_en = 1;
    if (mode == 3) vcount = 241;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cpu_addr = 0; bus.cpu_din = 0; bus.cpu_we = 0; bus.sma = 0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_smd", bus.smd, 0);
    check("rst_cpu_dout", bus.cpu_dout, 0);
    reset = 0; tick();
    for (int i = 0; i < 256; i++) cpu_wr(8'(i), 8'(i) ^ 8'h5A);
    cpu_rd(8'h33);
    run_copy(0);
    check("c1_busy_cycles", nb, 257);
    check("c1_done_count", nd, 1);
    check("c1_done_pos", dpos, 257);
    disp_m = live_m;
    nb = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy) nb++;
      tick();
    end
    check("hold240_busy", nb, 0);
    vcount = 241; tick();
    eng_rd(8'h00); eng_rd(8'h7F); eng_rd(8'hFF);
    check("c1_model_7f", disp_m[8'h7F], 8'h25);

    copy_en = 0;
    cpu_wr(8'h00, 8'h11);
    vcount = 239; tick(); vcount = 240;
    nb = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy) nb++;
      tick();
    end
    check("dis_busy", nb, 0);
    copy_en = 1; vcount = 241; tick();
    eng_rd(8'h00);

    pre_m = live_m;
    run_copy(1);
    live_m[8'h10] = 8'hC3; live_m[8'hF0] = 8'h3C;
    check("c3_busy_cycles", nb, 257);
    check("c3_done_count", nd, 1);
    disp_m = pre_m; disp_m[8'hF0] = 8'h3C;
    vcount = 241; tick();
    eng_rd(8'h10); eng_rd(8'hF0); eng_rd(8'h00);
    run_copy(0);
    check("c3b_busy_cycles", nb, 257);
    disp_m = live_m;
    vcount = 241; tick();
    eng_rd(8'h10);

    cpu_wr(8'h80, 8'h77);
    run_copy(2);
    check("c4_busy_cycles", nb, 257);
    check("c4_done_pos", dpos, 257);
    disp_m = live_m;
    vcount = 241; tick();
    eng_rd(8'h80);

    for (int i = 0; i < 256; i++) cpu_wr(8'(i), ~8'(i));
    run_copy(3);
    check("c5_busy_cycles", nb, 100);
    check("c5_abort_cycle", endc, 101);
    check("c5_done_count", nd, 0);
    check("c5_done_after", done, 0);
    check("c5_smd_reset", bus.smd, 0);
    for (int i = 0; i < 8'h62; i++) disp_m[i] = live_m[i];
    eng_rd(8'h00); eng_rd(8'h61); eng_rd(8'h62); eng_rd(8'hFF);
    run_copy(0);
    check("c6_busy_cycles", nb, 257);
    check("c6_done_count", nd, 1);
    disp_m = live_m;
    vcount = 241; tick();
    eng_rd(8'h62); eng_rd(8'hFF);
    cpu_rd(8'hA5);
    repeat (3) tick();
    check("q_eng_empty", q_eng.size(), 0);
    check("q_cpu_empty", q_cpu.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
